// File: rtl/mdu_iter.sv
// Iterative RV64M multiply/divide unit: radix-2 shift-add multiply and restoring divide,
// one bit per cycle over 64 cycles, with divide-by-zero and signed overflow resolved at issue.
module mdu_iter (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic        busy,
  output logic        done,
  output logic [63:0] result
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state_q, state_d;
  logic [6:0]    cnt_q, cnt_d;
  logic [3:0]    op_q, op_d;
  logic [63:0]   opnd_q, opnd_d;
  logic [127:0]  work_q, work_d;
  logic          negq_q, negq_d;
  logic          negr_q, negr_d;
  logic [63:0]   result_q, result_d;

  // W variants keep only the low word, sign-extended; W forms of MULH* are defined as zero.
  function automatic logic [63:0] w_adjust(input logic [3:0] o, input logic [63:0] x);
    logic [63:0] y;
    y = x;
    if (o[3]) begin
      if (!o[2] && (o[1:0] != 2'b00)) y = 64'd0;
      else                            y = {{32{x[31]}}, x[31:0]};
    end
    return y;
  endfunction

  function automatic logic [63:0] finish_res(input logic [3:0] o, input logic [127:0] w,
                                             input logic nq, input logic nr);
    logic [127:0] p;
    logic [63:0]  q, r, x;
    p = nq ? -w : w;
    q = nq ? -w[63:0] : w[63:0];
    r = nr ? -w[127:64] : w[127:64];
    if (o[2])                 x = o[1] ? r : q;
    else if (o[1:0] == 2'b00) x = p[63:0];
    else                      x = p[127:64];
    return w_adjust(o, x);
  endfunction

  logic [2:0]  f3;
  logic        is_w, is_div, sext_w;
  logic        a_signed, b_signed, a_neg, b_neg;
  logic [63:0] a_prep, b_prep, a_mag, b_mag;
  logic        div_zero, div_ovf, special;
  logic [63:0] spec_raw;

  always_comb begin
    f3       = op[2:0];
    is_w     = op[3];
    is_div   = op[2];
    sext_w   = (f3 == 3'b000) || (f3 == 3'b100) || (f3 == 3'b110);
    a_prep   = a;
    b_prep   = b;
    if (is_w) begin
      a_prep = sext_w ? {{32{a[31]}}, a[31:0]} : {32'd0, a[31:0]};
      b_prep = sext_w ? {{32{b[31]}}, b[31:0]} : {32'd0, b[31:0]};
    end
    a_signed = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
               (f3 == 3'b100) || (f3 == 3'b110);
    b_signed = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b100) || (f3 == 3'b110);
    a_neg    = a_signed && a_prep[63];
    b_neg    = b_signed && b_prep[63];
    a_mag    = a_neg ? -a_prep : a_prep;
    b_mag    = b_neg ? -b_prep : b_prep;
    div_zero = is_div && (b_prep == 64'd0);
    div_ovf  = is_div && !is_w && !f3[0] &&
               (a_prep == 64'h8000_0000_0000_0000) && (b_prep == 64'hFFFF_FFFF_FFFF_FFFF);
    special  = div_zero || div_ovf;
    if (div_zero) spec_raw = f3[1] ? a_prep : 64'hFFFF_FFFF_FFFF_FFFF;
    else          spec_raw = f3[1] ? 64'd0 : a_prep;
  end

  // One iteration of each datapath; only the one matching op_q is used.
  logic [64:0]  mul_sum;
  logic [127:0] mul_next;
  logic [64:0]  div_top, div_diff;
  logic         div_ge;
  logic [127:0] div_next;

  always_comb begin
    mul_sum  = {1'b0, work_q[127:64]} + (work_q[0] ? {1'b0, opnd_q} : 65'd0);
    mul_next = {mul_sum, work_q[63:1]};
    div_top  = work_q[127:63];
    div_ge   = (div_top >= {1'b0, opnd_q});
    div_diff = div_top - {1'b0, opnd_q};
    div_next = {(div_ge ? div_diff[63:0] : div_top[63:0]), work_q[62:0], div_ge};
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    opnd_d   = opnd_q;
    work_d   = work_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    result_d = result_q;
    busy     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d   = op;
          negq_d = a_neg ^ b_neg;
          negr_d = a_neg;
          cnt_d  = 7'd0;
          if (is_div) begin
            opnd_d = b_mag;
            work_d = {64'd0, a_mag};
          end else begin
            opnd_d = a_mag;
            work_d = {64'd0, b_mag};
          end
          if (special) begin
            result_d = w_adjust(op, spec_raw);
            state_d  = DONE;
          end else begin
            busy    = 1'b1;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        busy   = 1'b1;
        work_d = op_q[2] ? div_next : mul_next;
        cnt_d  = cnt_q + 7'd1;
        if (cnt_q == 7'd63) begin
          cnt_d    = 7'd0;
          result_d = finish_res(op_q, work_d, negq_q, negr_q);
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 7'd0;
      op_q     <= 4'd0;
      opnd_q   <= 64'd0;
      work_q   <= 128'd0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      result_q <= 64'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      opnd_q   <= opnd_d;
      work_q   <= work_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      result_q <= result_d;
    end
  end

  assign done   = (state_q == DONE);
  assign result = result_q;

endmodule

// File: doc/mdu_iter.md
MDU_ITER -- requirements
Module: mdu_iter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports clk and rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 start  input  1  issue request, sampled only in IDLE.
REQ-005 op  input  4  op[2:0]=RV funct3 (000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU); op[3]=word (W) variant.
REQ-006 a, b  input  64 each  rs1/rs2 operands.
REQ-007 busy  output  1  unit occupied; drives the hazard unit's mALU_runing input.
REQ-008 done  output  1  one-cycle result-valid pulse.
REQ-009 result  output  64  RV64M result, held stable from done until the next accepted start.

Function
REQ-010 States SHALL be IDLE, CALC and DONE.
REQ-011 start in IDLE SHALL latch op and the prepared operands.
  - Go to DONE if the operation is a special case (REQ-017, REQ-018).
  - Otherwise go to CALC with the iteration counter cleared.
REQ-012 start in CALC or DONE SHALL be ignored.
REQ-013 busy SHALL be combinational: 1 when state==CALC, or when state==IDLE with start=1 and the operation is not a special case; 0 otherwise, including in DONE.
REQ-014 CALC SHALL run exactly 64 iterations on a 7-bit counter 0..63, then go to DONE.
  - Latency is 64 busy cycles after the start cycle.
  - done is asserted in cycle 65 after start.
REQ-015 DONE SHALL assert done=1 and register result for one cycle, then return to IDLE unconditionally.
REQ-016 Multiply SHALL use radix-2 shift-add on operand magnitudes into a 128-bit product, negated at the end when the operand signs differ.
  - MUL returns product[63:0]; MULH, MULHSU and MULHU return product[127:64].
  - MULH: both operands signed. MULHSU: a signed, b unsigned. MULHU: both unsigned.
REQ-017 Divide SHALL use restoring division on magnitudes (128-bit remainder/quotient shift register).
  - Signed quotient is negated when the operand signs differ.
  - Signed remainder takes the sign of the dividend.
REQ-018 Division by zero SHALL be a special case with no iterations: quotient = all ones; remainder = dividend after word preparation.
REQ-019 Signed overflow (DIV/REM, a=0x8000_0000_0000_0000, b=all ones) SHALL be a special case: quotient = a, remainder = 0.
REQ-020 W variants SHALL prepare operands from [31:0]: sign-extended for MULW, DIVW and REMW; zero-extended for DIVUW and REMUW.
  - The final result SHALL be the low 32 bits sign-extended to 64.
  - W overflow (-2^31 / -1) needs no special case.
REQ-021 op[3]=1 with funct3 001, 010 or 011 SHALL produce result=0 through the normal 64-cycle path.
REQ-022 Special cases SHALL present done in the cycle after start, with busy never asserted.

Reset
REQ-023 rst SHALL immediately force: state=IDLE, counter=0, result=0, done=0, latched op and operands=0.
REQ-024 rst asserted mid-CALC SHALL abort the operation with no done pulse; busy=0 while rst is high and start=0.
REQ-025 After rst deasserts, the first rising edge SHALL be able to accept start.

Verification
REQ-026 MUL a=7, b=-3: busy=1 for start cycle plus 64 cycles; done at cycle 65; result=0xFFFF_FFFF_FFFF_FFEB.
REQ-027 MULHU a=b=0xFFFF_FFFF_FFFF_FFFF -> result=0xFFFF_FFFF_FFFF_FFFE; MULH on the same operands -> result=0.
REQ-028 DIV a=-20, b=3 -> result=-6; REM on the same operands -> result=-2.
  - DIVU a=20, b=0 -> done one cycle after start, busy never high, result=0xFFFF_FFFF_FFFF_FFFF.
REQ-029 REM a=0x8000_0000_0000_0000, b=-1 -> result=0; DIVW a=0x8000_0000, b=0xFFFF_FFFF -> result=0xFFFF_FFFF_8000_0000.
REQ-030 Second start asserted in cycle 10 of CALC -> ignored; first result unchanged.
  - rst pulsed in cycle 30 of a DIV -> no done pulse, busy=0.
  - A new MULW a=0x10000, b=0x10000 then completes with result=0.
